// File: rtl/logo_anim_ctrl_pkg.sv
// logo_anim_ctrl_pkg: shared VGA constants, logo state encoding and direction type.
package logo_anim_ctrl_pkg;
    localparam int DELT_W   = 11;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int LOGO_Y   = 200;
    localparam int LOGO_H   = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MOVE_R  = 3'd1,
        MOVE_L  = 3'd2,
        DWELL_R = 3'd3,
        DWELL_L = 3'd4
    } state_t;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } dir_t;
endpackage

// File: rtl/logo_anim_ctrl_vsync_edge_sync.sv
// vsync_edge_sync: two-flop synchroniser for active-low vsync plus falling-edge detect.
module vsync_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic fall
);
    logic s1, s2, h;
    // Flops reset to the idle-high level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst)
        if (!rst) {s1, s2, h} <= 3'b111;
        else      {s1, s2, h} <= {vsync, s1, s2};
    assign fall = h & ~s2;
endmodule

// File: rtl/logo_anim_ctrl.sv
// logo_anim_ctrl: frame-locked sequencer moving the logo between 0 and DELT_MAX, blinking at each end.
module logo_anim_ctrl
    import logo_anim_ctrl_pkg::*;
#(
    parameter int DELT_MAX     = 200,
    parameter int DWELL_FRAMES = 32,
    parameter int BLINK_FRAMES = 8,
    parameter int FRAME_DIV    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              run,
    input  logic [2:0]        speed,
    output logic [DELT_W-1:0] delt,
    output logic              enble,
    output logic              frame_tick,
    output logic              at_edge
);
    localparam int SW = DELT_W + 1;
    localparam int FW = $clog2(FRAME_DIV + 1);
    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    state_t         st;
    dir_t           dir;
    logic [FW-1:0]  fcnt;
    logic [DW-1:0]  dcnt;
    logic [BW-1:0]  bcnt;
    logic           saved;
    logic           fall;
    logic           step;
    logic [SW-1:0]  sum;

    vsync_edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .vsync (vsync),
        .fall  (fall)
    );

    assign step = fcnt == FW'(FRAME_DIV - 1);
    assign sum  = {1'b0, delt} + SW'(speed);

    // saved marks an interrupted dwell so that resuming from IDLE re-enters it.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st         <= IDLE;
            dir        <= RIGHT;
            fcnt       <= '0;
            dcnt       <= '0;
            bcnt       <= '0;
            saved      <= 1'b0;
            delt       <= '0;
            enble      <= 1'b0;
            frame_tick <= 1'b0;
            at_edge    <= 1'b0;
        end else begin
            frame_tick <= fall;
            if (frame_tick) begin
                fcnt <= step ? '0 : fcnt + 1'b1;
                if (!run && st != IDLE) begin
                    st      <= IDLE;
                    enble   <= 1'b1;
                    at_edge <= 1'b0;
                end else
                    case (st)
                        IDLE: begin
                            enble <= 1'b1;
                            if (run) begin
                                st      <= saved ? (dir == RIGHT ? DWELL_R : DWELL_L)
                                                 : (dir == RIGHT ? MOVE_R : MOVE_L);
                                at_edge <= saved;
                            end
                        end
                        MOVE_R:
                            if (step && speed != 3'd0) begin
                                if (sum >= SW'(DELT_MAX)) begin
                                    delt    <= DELT_W'(DELT_MAX);
                                    st      <= DWELL_R;
                                    dcnt    <= '0;
                                    bcnt    <= '0;
                                    saved   <= 1'b1;
                                    at_edge <= 1'b1;
                                end else
                                    delt <= sum[DELT_W-1:0];
                            end
                        MOVE_L:
                            if (step && speed != 3'd0) begin
                                if (delt <= DELT_W'(speed)) begin
                                    delt    <= '0;
                                    st      <= DWELL_L;
                                    dcnt    <= '0;
                                    bcnt    <= '0;
                                    saved   <= 1'b1;
                                    at_edge <= 1'b1;
                                end else
                                    delt <= delt - DELT_W'(speed);
                            end
                        default:
                            if (dcnt == DW'(DWELL_FRAMES - 1)) begin
                                enble   <= 1'b1;
                                dir     <= dir == RIGHT ? LEFT : RIGHT;
                                st      <= st == DWELL_R ? MOVE_L : MOVE_R;
                                saved   <= 1'b0;
                                at_edge <= 1'b0;
                            end else begin
                                dcnt <= dcnt + 1'b1;
                                bcnt <= bcnt == BW'(BLINK_FRAMES - 1) ? '0 : bcnt + 1'b1;
                                if (bcnt == BW'(BLINK_FRAMES - 1)) enble <= ~enble;
                            end
                    endcase
            end
        end
endmodule

// File: tb/tb_logo_anim_ctrl.sv
// tb_logo_anim_ctrl: table vectors, directed corner sequences and random frames against a frame-level model.
module tb_logo_anim_ctrl;
    localparam int DM = 200, DF = 32, BF = 8, FD = 2;

    logic        clk = 1'b0, rst = 1'b0, vsync = 1'b1, run = 1'b0;
    logic [2:0]  speed = 3'd0;
    logic [10:0] delt;
    logic        enble, frame_tick, at_edge;

    always #5 clk = ~clk;

    logo_anim_ctrl #(.DELT_MAX(DM), .DWELL_FRAMES(DF), .BLINK_FRAMES(BF), .FRAME_DIV(FD)) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .run(run), .speed(speed),
        .delt(delt), .enble(enble), .frame_tick(frame_tick), .at_edge(at_edge)
    );

    int vectors = 0, miscompares = 0;

    typedef enum {M_IDLE, M_MOVE, M_DWELL} mmode_t;
    mmode_t m_mode;
    bit     m_right, m_saved, m_en;
    int     m_pos, m_d, m_ticks, peak;

    typedef struct {bit r; int s; int d; bit e; bit g;} vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_right = 1; m_saved = 0; m_en = 0;
        m_pos = 0; m_d = 0; m_ticks = 0;
    endtask

    task automatic enter_dwell();
        m_mode = M_DWELL; m_saved = 1; m_d = 0;
    endtask

    // One frame of behaviour: position moves every FD-th frame, dwell lasts DF frames, blink flips every BF dwell frames.
    task automatic model_tick(input bit r, input int s);
        bit step;
        step = (m_ticks % FD) == FD - 1;
        m_ticks++;
        if (m_mode != M_IDLE && !r) begin
            m_mode = M_IDLE; m_en = 1;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_en = 1;
                if (r) m_mode = m_saved ? M_DWELL : M_MOVE;
            end
            M_MOVE: if (step && s > 0) begin
                if (m_right && m_pos + s >= DM) begin m_pos = DM; enter_dwell(); end
                else if (!m_right && m_pos <= s) begin m_pos = 0; enter_dwell(); end
                else m_pos = m_right ? m_pos + s : m_pos - s;
            end
            default: if (m_d == DF - 1) begin
                m_en = 1; m_right = !m_right; m_saved = 0; m_mode = M_MOVE;
            end else begin
                m_d++;
                if (m_d % BF == 0) m_en = !m_en;
            end
        endcase
    endtask

    task automatic do_frame(input bit r, input int s);
        int ticks;
        ticks = 0;
        @(negedge clk); run = r; speed = 3'(s); vsync = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (frame_tick) ticks++; end
        @(negedge clk); vsync = 1'b1;
        repeat (6) begin @(posedge clk); #1; if (frame_tick) ticks++; end
        model_tick(r, s);
        if (int'(delt) > peak) peak = int'(delt);
        chk("tick_count", ticks, 1);
        chk("delt", int'(delt), m_pos);
        chk("enble", int'(enble), int'(m_en));
        chk("at_edge", int'(at_edge), int'(m_mode == M_DWELL));
    endtask

    initial begin
        int first, width, en3, en4, edge_frames, en_changes, k, last, cnt, s;
        bit last_en, saw5;
        int v[2];
        tbl[0] = '{1, 4, 0, 1, 0};  tbl[1] = '{1, 4, 0, 1, 0};  tbl[2] = '{1, 4, 4, 1, 0};
        tbl[3] = '{1, 4, 4, 1, 0};  tbl[4] = '{1, 4, 8, 1, 0};  tbl[5] = '{0, 4, 8, 1, 0};
        tbl[6] = '{1, 4, 8, 1, 0};  tbl[7] = '{1, 4, 8, 1, 0};  tbl[8] = '{1, 4, 12, 1, 0};
        model_reset();
        peak = 0;
        repeat (3) #7 vsync = ~vsync;
        #3;
        chk("rst_delt", int'(delt), 0);
        chk("rst_enble", int'(enble), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_edge", int'(at_edge), 0);
        vsync = 1'b1;
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_enble", int'(enble), 0);

        first = 0; width = 0; en3 = -1; en4 = -1;
        vsync = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (frame_tick) begin width++; if (first == 0) first = n; end
            if (n == 3) en3 = int'(enble);
            if (n == 4) en4 = int'(enble);
        end
        @(negedge clk); vsync = 1'b1;
        repeat (4) @(posedge clk);
        model_tick(0, 0);
        chk("tick_latency", first, 3);
        chk("tick_width", width, 1);
        chk("enble_before_tick", en3, 0);
        chk("enble_after_tick", en4, 1);

        for (int i = 0; i < 9; i++) begin
            do_frame(tbl[i].r, tbl[i].s);
            chk("tbl_delt", int'(delt), tbl[i].d);
            chk("tbl_enble", int'(enble), int'(tbl[i].e));
            chk("tbl_edge", int'(at_edge), int'(tbl[i].g));
        end

        for (int i = 0; i < 200 && m_pos != 196; i++) do_frame(1, 4);
        chk("reach_196", int'(delt), 196);
        for (int i = 0; i < 10 && !at_edge; i++) do_frame(1, 7);
        chk("clamp_200", int'(delt), DM);
        chk("peak", peak, DM);
        edge_frames = 1; en_changes = 0; last_en = enble;
        for (int i = 0; i < 40 && at_edge; i++) begin
            do_frame(1, 7);
            if (at_edge) edge_frames++;
            if (enble != last_en) en_changes++;
            last_en = enble;
        end
        chk("dwell_len", edge_frames, DF);
        chk("blink_changes", en_changes, 4);
        k = 0; last = int'(delt); v[0] = 0; v[1] = 0;
        for (int i = 0; i < 20 && k < 2; i++) begin
            do_frame(1, 7);
            if (int'(delt) != last) begin v[k] = int'(delt); k++; last = int'(delt); end
        end
        chk("left_step1", v[0], 193);
        chk("left_step2", v[1], 186);

        saw5 = 0;
        for (int i = 0; i < 200 && !at_edge; i++) begin
            s = (m_pos > 5 && (m_pos - 5) % 7 != 0) ? 6 : 7;
            do_frame(1, s);
            if (delt == 11'd5) saw5 = 1;
        end
        chk("saw_5", int'(saw5), 1);
        chk("floor_0", int'(delt), 0);
        chk("dwell_l", int'(at_edge), 1);

        repeat (10) do_frame(1, 7);
        repeat (3) do_frame(0, 7);
        chk("pause_enble", int'(enble), 1);
        chk("pause_edge", int'(at_edge), 0);
        chk("pause_delt", int'(delt), 0);
        do_frame(1, 7);
        chk("resume_edge", int'(at_edge), 1);
        cnt = 0;
        for (int i = 0; i < 40 && at_edge; i++) begin do_frame(1, 7); cnt++; end
        chk("resume_len", cnt, 22);

        for (int i = 0; i < 400 && !(m_mode == M_MOVE && !m_right && m_pos == 120); i++) do_frame(1, 4);
        chk("at_120", int'(delt), 120);
        @(negedge clk); #2 rst = 1'b0;
        #1;
        chk("async_delt", int'(delt), 0);
        chk("async_enble", int'(enble), 0);
        chk("async_edge", int'(at_edge), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (4) do_frame(1, 4);
        chk("restart_right", int'(delt), 8);

        for (int i = 0; i < 300; i++) do_frame($urandom_range(0, 9) != 0, int'($urandom_range(0, 7)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/logo_anim_ctrl.md
Name: logo_anim_ctrl

Overview:
- Frame-synchronous sequencer for the logo painters: drives the shared horizontal offset `delt` and the visibility enable `enble` consumed by the logo glyph rectangles.
- Moves the logo right/left between 0 and DELT_MAX, dwells and blinks at each end.
- Updates only at frame start, so a frame never shows a partly moved logo.
- Sits between VGA sync generation and the logo paint blocks.

Parameters:
- DELT_MAX, 200, right-hand limit of `delt` in pixels (must be ≤ 2047 − SPEED max).
- DWELL_FRAMES, 32, frames spent in dwell at each end.
- BLINK_FRAMES, 8, frames per enble half-period while dwelling.
- FRAME_DIV, 2, frames between position steps (≥1).

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous active-low reset
- vsync  in  1  VGA vertical sync, active-low, asynchronous to logic (2-flop sync required)
- run  in  1  1 = animate, 0 = freeze position (logo still shown)
- speed  in  3  pixels per step; 0 = no motion; sampled at each step
- delt  out  11  horizontal offset to logo painters
- enble  out  1  logo visible
- frame_tick  out  1  one-cycle pulse per frame start
- at_edge  out  1  high while in a dwell state

Behaviour:
- Reset (rst=0, async): delt=0, enble=0, frame_tick=0, at_edge=0, state=IDLE, dir=RIGHT, frame/dwell/blink counters=0.
- vsync passes through 2 sync flops plus 1 history flop; a falling edge on the synced signal gives frame_tick=1 for exactly one clk. Latency from vsync falling edge is 3 clk.
- All state, counter and output updates occur only on the clk edge where frame_tick=1, except the reset.
- Step divider: frame counter counts 0..FRAME_DIV−1 on each frame_tick. A "step" is a frame_tick with counter=FRAME_DIV−1. The counter wraps to 0 and runs in every state.
- States: IDLE, MOVE_R, MOVE_L, DWELL_R, DWELL_L.
- IDLE:
  - enble=1 from the first frame_tick after reset.
  - delt held.
  - If run=1 at a frame_tick: go to MOVE_R if dir=RIGHT, else MOVE_L.
- MOVE_R, at a step:
  - If delt+speed ≥ DELT_MAX: delt=DELT_MAX, go to DWELL_R, dwell counter=0.
  - Otherwise delt=delt+speed.
  - Use a 12-bit add; no wrap is permitted.
- MOVE_L, at a step:
  - If delt ≤ speed: delt=0, go to DWELL_L.
  - Otherwise delt=delt−speed.
  - No underflow.
- DWELL_x:
  - at_edge=1.
  - The dwell counter increments per frame_tick.
  - enble toggles whenever the blink counter reaches BLINK_FRAMES−1; the blink counter then resets.
  - When the dwell counter reaches DWELL_FRAMES−1: enble=1, dir flips, go to the opposite MOVE state.
- run=0 at any frame_tick, in any state except IDLE:
  - Go to IDLE and keep dir.
  - Leaving DWELL: enble forced to 1; the dwell counter is kept.
  - When run returns and the block resumes: a saved dwell continues, and motion continues in the same direction.
- speed=0 in a MOVE state: delt holds and there is no transition. A speed change takes effect at the next step.
- run and the edge condition in the same frame: run=0 has priority (IDLE, delt unchanged).
- frame_tick coincident with reset release: ignored.

Decomposition:
- Shared VGA package holds:
  - state encoding (3-bit localparams IDLE=0, MOVE_R=1, MOVE_L=2, DWELL_R=3, DWELL_L=4)
  - the DELT width constant (11)
  - the screen geometry constants used by the logo painters
- One natural sub-module: vsync_edge_sync (2-flop synchroniser + falling-edge pulse, async active-low reset). It is reusable by other frame-locked VGA blocks.

Test Plan:
- Reset with vsync toggling, rst released → delt=0, enble=0 until the first frame_tick, then enble=1. frame_tick is 1 clk wide, 3 clk after each vsync fall.
- run=1, speed=4, FRAME_DIV=2 → delt advances 0,4,8,… every 2 frames. It reaches exactly 200 and asserts at_edge; it never exceeds 200.
- speed=7 from delt=196 → clamps to 200 (no 203) and enters DWELL_R. enble toggles every 8 frames, returns to 1 after 32 frames, then delt decreases 193,186,… .
- MOVE_L at delt=5 with speed=7 → delt=0, DWELL_L, then MOVE_R.
- Drop run mid-dwell at dwell count 10 → enble=1, delt frozen. Re-assert run → dwell resumes and ends after 22 more frames.
- Assert rst mid-MOVE_L at delt=120 → immediate delt=0, enble=0, dir=RIGHT. After release, motion restarts rightward from 0.
